fifo_push_arbiter: RTL

Round-robin arbiter that shares the single write port of one `fifo_v3` instance among `NUM_REQ` requesters. It sits directly in front of the FIFO push side. It selects one requester per cycle and gates grants with the FIFO full flag. Optionally it locks the port to one requester for a bounded burst so that multi-beat transfers stay contiguous in the queue.

---
 rtl/fifo_push_arbiter_if.sv | 29 ++
 rtl/fifo_push_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter_if.sv
// Push-side bundle between NUM_REQ requesters, the arbiter and one fifo_v3 write port.
interface fifo_push_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic                            flush_i;
  logic [NUM_REQ-1:0]              req_i;
  logic [NUM_REQ-1:0]              lock_i;
  logic [NUM_REQ*DATA_WIDTH-1:0]   data_i;
  logic [NUM_REQ-1:0]              gnt_o;
  logic                            fifo_full_i;
  logic                            fifo_push_o;
  logic [DATA_WIDTH-1:0]           fifo_data_o;
  logic                            fifo_flush_o;
  logic [IDX_W-1:0]                owner_o;
  logic                            locked_o;

  modport master (
    output flush_i, req_i, lock_i, data_i, fifo_full_i,
    input  gnt_o, fifo_push_o, fifo_data_o, fifo_flush_o, owner_o, locked_o
  );

  modport slave (
    input  flush_i, req_i, lock_i, data_i, fifo_full_i,
    output gnt_o, fifo_push_o, fifo_data_o, fifo_flush_o, owner_o, locked_o
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter for a shared FIFO push port, gated by FIFO full.
// Optional burst lock compiled in with FIFO_ARB_BURST_LOCK_EN.
module fifo_push_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  fifo_push_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CW    = $clog2(MAX_BURST) + 1;

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] arb_cand;
  logic             arb_valid;
  logic [IDX_W-1:0] cand;
  logic             cand_valid;
  logic             grant;
  logic [IDX_W:0]   scan_idx;

  // Rotating scan starting just after the last granted requester.
  always_comb begin
    arb_cand  = '0;
    arb_valid = 1'b0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (IDX_W+1)'(last_q) + (IDX_W+1)'(i + 1);
      if (scan_idx >= (IDX_W+1)'(NUM_REQ)) scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
      if (!arb_valid && bus.req_i[scan_idx[IDX_W-1:0]]) begin
        arb_cand  = scan_idx[IDX_W-1:0];
        arb_valid = 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_BURST_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_e;

  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  state_e           state_q;
  logic [IDX_W-1:0] owner_q;
  logic [CW-1:0]    beat_cnt_q;

  always_comb begin
    if (state_q == LOCKED) begin
      cand       = owner_q;
      cand_valid = bus.req_i[owner_q];
    end else begin
      cand       = arb_cand;
      cand_valid = arb_valid;
    end
  end

  // Flush beats full: a flushed FIFO is never full on the following cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      last_q     <= IDX_W'(NUM_REQ - 1);
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else if (bus.flush_i) begin
      state_q    <= ARB;
      beat_cnt_q <= '0;
    end else if (!bus.fifo_full_i) begin
      case (state_q)
        ARB: begin
          if (grant) begin
            last_q <= cand;
            if (bus.lock_i[cand] && (MAX_BURST > 1)) begin
              state_q    <= LOCKED;
              owner_q    <= cand;
              beat_cnt_q <= CW'(1);
            end
          end
        end
        LOCKED: begin
          if (grant) begin
            last_q <= owner_q;
            if (!bus.lock_i[owner_q] || (beat_cnt_q == LAST_CNT)) begin
              state_q    <= ARB;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + CW'(1);
            end
          end else if (!bus.lock_i[owner_q]) begin
            state_q    <= ARB;
            beat_cnt_q <= '0;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign bus.locked_o = (state_q == LOCKED);
`else
  logic unused_cfg;

  assign cand       = arb_cand;
  assign cand_valid = arb_valid;
  assign unused_cfg = ^{bus.lock_i, MAX_BURST[0], CW[0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else if (grant) begin
      last_q <= cand;
    end
  end

  assign bus.locked_o = 1'b0;
`endif

  // Reset also masks grants so nothing is pushed while the pointer is being cleared.
  assign grant = cand_valid & ~bus.fifo_full_i & ~bus.flush_i & ~rst_i;

  always_comb begin
    bus.gnt_o       = '0;
    bus.gnt_o[cand] = grant;
    bus.fifo_data_o = grant ? bus.data_i[int'(cand)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign bus.fifo_push_o  = grant;
  assign bus.fifo_flush_o = bus.flush_i;
  assign bus.owner_o      = last_q;
endmodule
